// File: rtl/topk_sort_gen_if.sv
// topk_sort_gen_if: batch-in / top-K-out handshake bundle for topk_sort_gen.
// The source drives the master side and the sorter drives the slave side.
interface topk_sort_gen_if #(
    parameter int DATA_W = 8,
    parameter int IDX_W  = 16,
    parameter int LANES  = 16,
    parameter int GROUPS = 2,
    parameter int TOPK   = 5
);
    logic                                  in_valid;
    logic                                  in_ready;
    logic                                  in_last;
    logic [DATA_W*LANES*GROUPS-1:0]        sort_in;
    logic                                  out_valid;
    logic                                  out_ready;
    logic                                  out_last;
    logic [(IDX_W+DATA_W)*TOPK*GROUPS-1:0] out_data;
    logic [IDX_W-1:0]                      out_batch_cnt;

    modport master (
        output in_valid, in_last, sort_in, out_ready,
        input  in_ready, out_valid, out_last, out_data, out_batch_cnt
    );
    modport slave (
        input  in_valid, in_last, sort_in, out_ready,
        output in_ready, out_valid, out_last, out_data, out_batch_cnt
    );
endinterface

// File: rtl/topk_sort_gen.sv
// topk_sort_gen: per-group iterative top-K selection over a latched batch of lane values.
// One winner per group per SEL cycle; taken lanes are masked out of later rounds.
module topk_sort_gen #(
    parameter int DATA_W = 8,
    parameter int IDX_W  = 16,
    parameter int LANES  = 16,
    parameter int GROUPS = 2,
    parameter int TOPK   = 5,
    parameter int SIGNED = 1
) (
    input  logic           sys_clk,
    input  logic           sys_rst_n,
    input  logic           sorter_clr,
    topk_sort_gen_if.slave bus
);
    localparam int NL   = LANES * GROUPS;
    localparam int EW   = IDX_W + DATA_W;
    localparam int IT_W = TOPK > 1 ? $clog2(TOPK) : 1;

    typedef enum logic [1:0] {IDLE, SEL, DONE} state_t;

    state_t                    r_state, w_nxt;
    logic [IT_W-1:0]           r_iter;
    logic [DATA_W*NL-1:0]      r_data;
    logic [NL-1:0]             r_taken;
    logic [IDX_W-1:0]          r_cnt;
    logic                      r_last;
    logic [EW*TOPK*GROUPS-1:0] r_out;
    logic [NL-1:0]             w_sel;
    logic [DATA_W-1:0]         w_val [GROUPS];
    logic [IDX_W-1:0]          w_idx [GROUPS];
    logic                      w_hit;
    logic                      w_acc;
    int                        w_b;

    function automatic logic f_gt(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        return (SIGNED != 0) ? ($signed(a) > $signed(b)) : (a > b);
    endfunction

    assign w_acc             = (r_state == IDLE) && bus.in_valid;
    assign bus.in_ready      = (r_state == IDLE);
    assign bus.out_valid     = (r_state == DONE);
    assign bus.out_data      = r_out;
    assign bus.out_last      = r_last;
    assign bus.out_batch_cnt = r_cnt;

    // Strict greater-than keeps the first (lowest) lane on ties; w_hit lets the
    // minimum representable value still win when it is all that is left.
    always_comb begin
        w_sel = '0;
        w_hit = 1'b0;
        w_b   = 0;
        for (int g = 0; g < GROUPS; g++) begin
            w_hit    = 1'b0;
            w_b      = 0;
            w_val[g] = '0;
            for (int l = 0; l < LANES; l++)
                if (!r_taken[g*LANES+l] &&
                    (!w_hit || f_gt(r_data[(g*LANES+l)*DATA_W +: DATA_W], w_val[g]))) begin
                    w_hit    = 1'b1;
                    w_b      = l;
                    w_val[g] = r_data[(g*LANES+l)*DATA_W +: DATA_W];
                end
            w_idx[g]           = IDX_W'(g*LANES + w_b);
            w_sel[g*LANES+w_b] = w_hit;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n)
        if (!sys_rst_n) r_state <= IDLE;
        else            r_state <= w_nxt;

    always_comb begin
        w_nxt = r_state;
        if (sorter_clr)           w_nxt = IDLE;
        else if (r_state == IDLE) w_nxt = bus.in_valid ? SEL : IDLE;
        else if (r_state == SEL)  w_nxt = (r_iter == IT_W'(TOPK-1)) ? DONE : SEL;
        else                      w_nxt = bus.out_ready ? IDLE : DONE;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n)
        if (!sys_rst_n) begin
            r_iter  <= '0;
            r_data  <= '0;
            r_taken <= '0;
            r_cnt   <= '0;
            r_last  <= 1'b0;
            r_out   <= '0;
        end else if (sorter_clr) begin
            r_iter  <= '0;
            r_data  <= '0;
            r_taken <= '0;
            r_cnt   <= '0;
            r_last  <= 1'b0;
            r_out   <= '0;
        end else if (w_acc) begin
            r_iter  <= '0;
            r_data  <= bus.sort_in;
            r_taken <= '0;
            r_cnt   <= r_cnt + 1'b1;
            r_last  <= bus.in_last;
        end else if (r_state == SEL) begin
            r_iter  <= r_iter + 1'b1;
            r_taken <= r_taken | w_sel;
            for (int g = 0; g < GROUPS; g++)
                r_out[(g*TOPK + int'(r_iter))*EW +: EW] <= {w_idx[g], w_val[g]};
        end
endmodule

// File: tb/tb_topk_sort_gen.sv
// tb_topk_sort_gen: directed and randomized checks of topk_sort_gen against a rank-based model.
// dut_a uses the defaults; dut_b is a small unsigned build with a 4-bit counter and TOPK==LANES.
module tb_topk_sort_gen;
    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b1;
    logic clr_a     = 1'b0;
    logic clr_b     = 1'b0;
    int   checks    = 0;
    int   errors    = 0;

    always #5 sys_clk = ~sys_clk;

    topk_sort_gen_if ia ();
    topk_sort_gen_if #(.IDX_W(4), .LANES(4), .TOPK(4)) ib ();

    topk_sort_gen dut_a (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .sorter_clr(clr_a), .bus(ia));
    topk_sort_gen #(.IDX_W(4), .LANES(4), .TOPK(4), .SIGNED(0))
        dut_b (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .sorter_clr(clr_b), .bus(ib));

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic ov(input bit s);
        return s ? ib.out_valid : ia.out_valid;
    endfunction
    function automatic logic ir(input bit s);
        return s ? ib.in_ready : ia.in_ready;
    endfunction
    function automatic logic ol(input bit s);
        return s ? ib.out_last : ia.out_last;
    endfunction
    function automatic logic [15:0] oc(input bit s);
        return s ? 16'(ib.out_batch_cnt) : ia.out_batch_cnt;
    endfunction
    function automatic logic [255:0] od(input bit s);
        return s ? 256'(ib.out_data) : 256'(ia.out_data);
    endfunction

    task automatic drive(input bit s, input logic v, input logic [255:0] d, input logic last);
        if (s) begin ib.in_valid = v; ib.sort_in = d[63:0]; ib.in_last = last; end
        else   begin ia.in_valid = v; ia.sort_in = d;       ia.in_last = last; end
    endtask
    task automatic ordy(input bit s, input logic v);
        if (s) ib.out_ready = v;
        else   ia.out_ready = v;
    endtask

    function automatic int key(input logic [255:0] d, input int i, input bit sgn);
        logic [7:0] v;
        v = d[i*8 +: 8];
        return sgn ? int'($signed(v)) : int'(v);
    endfunction

    // A lane's slot is its rank: how many lanes of its group beat it
    // (larger value, or equal value at a lower lane number).
    function automatic logic [255:0] model(input bit s, input logic [255:0] d);
        logic [255:0] r;
        int lanes, topk, ew, rank;
        logic [31:0] w;
        bit sgn;
        lanes = s ? 4 : 16;
        topk  = s ? 4 : 5;
        ew    = s ? 12 : 24;
        sgn   = !s;
        r     = '0;
        for (int g = 0; g < 2; g++)
            for (int l = 0; l < lanes; l++) begin
                rank = 0;
                for (int j = 0; j < lanes; j++)
                    if (key(d, g*lanes+j, sgn) > key(d, g*lanes+l, sgn) ||
                        (key(d, g*lanes+j, sgn) == key(d, g*lanes+l, sgn) && j < l)) rank++;
                if (rank < topk) begin
                    w = (32'(g*lanes+l) << 8) | 32'(d[(g*lanes+l)*8 +: 8]);
                    for (int b = 0; b < ew; b++) r[(g*topk+rank)*ew + b] = w[b];
                end
            end
        return r;
    endfunction

    function automatic logic [255:0] rnd(input logic [7:0] m);
        logic [255:0] r;
        for (int i = 0; i < 32; i++) r[i*8 +: 8] = 8'($urandom) & m;
        return r;
    endfunction

    task automatic run(input bit s, input logic [255:0] d, input logic last, input int cnt,
                       input string tag, output logic [255:0] got);
        int n;
        drive(s, 1'b1, d, last);
        for (n = 0; n < 20 && !ir(s); n++) @(negedge sys_clk);
        @(negedge sys_clk);
        drive(s, 1'b0, d, last);
        for (n = 0; n < 50 && !ov(s); n++) @(negedge sys_clk);
        got = od(s);
        chk({tag, "_lat"}, n, s ? 4 : 5);
        chk({tag, "_data"}, got, model(s, d));
        chk({tag, "_cnt"}, oc(s), cnt);
        chk({tag, "_last"}, ol(s), last);
        ordy(s, 1'b1);
        @(negedge sys_clk);
        ordy(s, 1'b0);
        chk({tag, "_rdy"}, {ov(s), ir(s)}, 2'b01);
    endtask

    initial begin
        logic [255:0] d, d2, got;
        int ca, n;
        logic seen;
        ca = 0;
        drive(0, 1'b0, '0, 1'b0);
        drive(1, 1'b0, '0, 1'b0);
        ordy(0, 1'b0);
        ordy(1, 1'b0);
        #2 sys_rst_n = 1'b0;
        #1;
        chk("rst_a_flags", {ia.in_ready, ia.out_valid, ia.out_last}, 3'b100);
        chk("rst_a_data", od(0), '0);
        chk("rst_a_cnt", oc(0), 0);
        chk("rst_b_flags", {ib.in_ready, ib.out_valid}, 2'b10);
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        // distinct values, ascending in group 0 and descending in group 1
        d = '0;
        for (int l = 0; l < 16; l++) begin
            d[l*8 +: 8]      = 8'(l);
            d[(16+l)*8 +: 8] = 8'(15-l);
        end
        ca++;
        run(0, d, 1'b1, ca, "distinct", got);
        for (int k = 0; k < 5; k++) begin
            chk("distinct_g0", got[k*24 +: 24], {16'(15-k), 8'(15-k)});
            chk("distinct_g1", got[(5+k)*24 +: 24], {16'(16+k), 8'(15-k)});
        end
        d = {32{8'h80}};
        ca++;
        run(0, d, 1'b0, ca, "ties_min", got);
        for (int k = 0; k < 5; k++) begin
            chk("ties_g0", got[k*24 +: 24], {16'(k), 8'h80});
            chk("ties_g1", got[(5+k)*24 +: 24], {16'(16+k), 8'h80});
        end
        d[7:0]  = 8'hFF;
        d[15:8] = 8'h01;
        ca++;
        run(0, d, 1'b1, ca, "signed", got);
        chk("signed_s0", got[23:0], {16'd1, 8'h01});
        chk("signed_s1", got[47:24], {16'd0, 8'hFF});
        for (int i = 0; i < 8; i++) begin
            ca++;
            run(0, rnd(i[0] ? 8'h83 : 8'hFF), 1'($urandom), ca, "rand_a", got);
        end
        // backpressure with the next batch already waiting on the input
        d  = rnd(8'hFF);
        d2 = rnd(8'hFF);
        drive(0, 1'b1, d, 1'b1);
        @(negedge sys_clk);
        drive(0, 1'b1, d2, 1'b0);
        for (n = 0; n < 50 && !ov(0); n++) @(negedge sys_clk);
        chk("bp_lat", n, 5);
        chk("bp_data", od(0), model(0, d));
        chk("bp_cnt", oc(0), ca + 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge sys_clk);
            chk("bp_hold", {ov(0), ir(0)}, 2'b10);
            chk("bp_stable", od(0), model(0, d));
        end
        ordy(0, 1'b1);
        @(negedge sys_clk);
        ordy(0, 1'b0);
        chk("bp_release", {ov(0), ir(0)}, 2'b01);
        @(negedge sys_clk);
        drive(0, 1'b0, d2, 1'b0);
        ca += 2;
        chk("bp_cnt2", oc(0), ca);
        chk("bp_last2", ol(0), 1'b0);
        for (n = 0; n < 50 && !ov(0); n++) @(negedge sys_clk);
        chk("bp_lat2", n, 5);
        chk("bp_data2", od(0), model(0, d2));
        ordy(0, 1'b1);
        @(negedge sys_clk);
        ordy(0, 1'b0);
        // clear while iter==2
        d = rnd(8'hFF);
        drive(0, 1'b1, d, 1'b0);
        @(negedge sys_clk);
        drive(0, 1'b0, d, 1'b0);
        repeat (2) @(negedge sys_clk);
        clr_a = 1'b1;
        @(negedge sys_clk);
        clr_a = 1'b0;
        chk("clr_state", {ov(0), ir(0), oc(0)}, {2'b01, 16'd0});
        seen = 1'b0;
        repeat (8) begin
            @(negedge sys_clk);
            seen |= ov(0);
        end
        chk("clr_no_valid", seen, 1'b0);
        ca = 1;
        run(0, rnd(8'hFF), 1'b0, ca, "after_clr", got);
        // asynchronous reset while holding a result in DONE
        d = rnd(8'hFF);
        drive(0, 1'b1, d, 1'b1);
        @(negedge sys_clk);
        drive(0, 1'b0, d, 1'b1);
        for (n = 0; n < 50 && !ov(0); n++) @(negedge sys_clk);
        chk("pre_rst_valid", ov(0), 1'b1);
        sys_rst_n = 1'b0;
        #1;
        chk("rst_mid_flags", {ov(0), ir(0), ol(0), oc(0)}, {3'b010, 16'd0});
        chk("rst_mid_data", od(0), '0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        ca = 1;
        run(0, rnd(8'hFF), 1'b1, ca, "after_rst", got);
        // unsigned build: 17 batches wrap the 4-bit counter
        for (int i = 0; i < 17; i++) begin
            if (i == 0) begin
                d       = {32{8'h80}};
                d[7:0]  = 8'hFF;
                d[15:8] = 8'h01;
            end else d = rnd(i[0] ? 8'h81 : 8'hFF);
            run(1, d, 1'($urandom), (i + 1) % 16, "wrap_b", got);
            if (i == 0) begin
                chk("unsigned_s0", got[11:0], {4'd0, 8'hFF});
                chk("unsigned_s1", got[23:12], {4'd2, 8'h80});
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
